// File: rtl/piso_serializer_if.sv
// Load handshake and framed serial output of the parallel-in/serial-out serializer.
interface piso_serializer_if #(
    parameter int width = 1,
    parameter int depth = 130
);
    logic                     e;
    logic                     load_valid;
    logic                     load_ready;
    logic [width*depth-1:0]   load_data;
    logic [width-1:0]         q;
    logic                     q_valid;
    logic                     q_last;
    logic [depth-1:0]         state;

    modport master (
        output e, load_valid, load_data,
        input  load_ready, q, q_valid, q_last, state
    );

    modport slave (
        input  e, load_valid, load_data,
        output load_ready, q, q_valid, q_last, state
    );
endinterface

// File: rtl/piso_lane.sv
// One serial lane: parallel load or LSB-first shift with zero fill at the MSB.
module piso_lane #(
    parameter int depth = 130
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [depth-1:0] din,
    output logic             dout,
    output logic [depth-1:0] sr
);
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (ld) begin
            sr <= din;
        end else if (sh) begin
            sr <= {1'b0, sr[depth-1:1]};
        end
    end

    assign dout = sr[0];
endmodule

// File: rtl/piso_serializer.sv
// Multi-lane PISO serializer: shared bits-remaining counter and load handshake driving width lanes.
module piso_serializer #(
    parameter int width = 1,
    parameter int depth = 130
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);
    localparam int CW = $clog2(depth + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(depth);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0]    cnt;
    logic             accept;
    logic             shift;
    logic [width-1:0] q_bits;
    logic [depth-1:0] lane_sr [width];

    // A load on the final enabled bit replaces the shift, keeping back-to-back words gapless.
    always_comb begin
        bus.q_valid    = (cnt != '0);
        bus.q_last     = (cnt == CNT_ONE);
        bus.load_ready = (cnt == '0) | ((cnt == CNT_ONE) & bus.e);
        accept         = bus.load_valid & bus.load_ready;
        shift          = bus.e & bus.q_valid & ~accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_FULL;
        end else if (shift) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    for (genvar w = 0; w < width; w++) begin : g_lane
        piso_lane #(.depth(depth)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .ld   (accept),
            .sh   (shift),
            .din  (bus.load_data[w*depth +: depth]),
            .dout (q_bits[w]),
            .sr   (lane_sr[w])
        );
    end

    assign bus.q     = q_bits;
    assign bus.state = lane_sr[0];
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations checked each cycle against a bit-queue model.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    piso_serializer_if #(.width(1), .depth(8))   ifa ();
    piso_serializer_if #(.width(2), .depth(4))   ifb ();
    piso_serializer_if #(.width(1), .depth(130)) ifc ();

    piso_serializer #(.width(1), .depth(8))   dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    piso_serializer #(.width(2), .depth(4))   dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));
    piso_serializer #(.width(1), .depth(130)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc.slave));

    // Model: per DUT, the bits still to be sent; element i holds bit i of every lane.
    logic [1:0] mq [3][$];

    task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input int id, input logic r, input logic e, input logic lv,
                        input logic [259:0] data, input int w, input int d);
        bit ready;
        logic [1:0] bits;
        ready = (mq[id].size() == 0) || (mq[id].size() == 1 && e);
        if (r) begin
            mq[id].delete();
        end else if (lv && ready) begin
            mq[id].delete();
            for (int i = 0; i < d; i++) begin
                bits = '0;
                for (int l = 0; l < w; l++) bits[l] = data[l*d + i];
                mq[id].push_back(bits);
            end
        end else if (e && mq[id].size() > 0) begin
            void'(mq[id].pop_front());
        end
    endtask

    task automatic cmp(input int id, input logic e, input logic [1:0] q, input logic qv,
                       input logic ql, input logic lr, input logic [129:0] st);
        int sz;
        logic [129:0] exp_st;
        sz = mq[id].size();
        exp_st = '0;
        for (int i = 0; i < sz; i++) exp_st[i] = mq[id][i][0];
        chk($sformatf("d%0d_q", id), 130'(q), 130'((sz > 0) ? mq[id][0] : 2'b00));
        chk($sformatf("d%0d_q_valid", id), 130'(qv), 130'(sz != 0));
        chk($sformatf("d%0d_q_last", id), 130'(ql), 130'(sz == 1));
        chk($sformatf("d%0d_load_ready", id), 130'(lr), 130'((sz == 0) || (sz == 1 && e)));
        chk($sformatf("d%0d_state", id), st, exp_st);
    endtask

    always @(posedge clk) begin
        step(0, rst_a, ifa.e, ifa.load_valid, 260'(ifa.load_data), 1, 8);
        step(1, rst_b, ifb.e, ifb.load_valid, 260'(ifb.load_data), 2, 4);
        step(2, rst_c, ifc.e, ifc.load_valid, 260'(ifc.load_data), 1, 130);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, ifa.e, 2'(ifa.q), ifa.q_valid, ifa.q_last, ifa.load_ready, 130'(ifa.state));
            cmp(1, ifb.e, ifb.q, ifb.q_valid, ifb.q_last, ifb.load_ready, 130'(ifb.state));
            cmp(2, ifc.e, 2'(ifc.q), ifc.q_valid, ifc.q_last, ifc.load_ready, ifc.state);
        end
    end

    function automatic logic [129:0] r130();
        logic [159:0] t;
        for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
        return t[129:0];
    endfunction

    logic [16:0] s_q, s_v, s_l, s_r;
    logic [7:0]  st1, st2;
    int          n_en, n_last, hit_at;
    bit          done;

    initial begin
        ifa.e = 0; ifa.load_valid = 0; ifa.load_data = '0;
        ifb.e = 0; ifb.load_valid = 0; ifb.load_data = '0;
        ifc.e = 0; ifc.load_valid = 0; ifc.load_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_a = 0; rst_b = 0; rst_c = 0;
        @(negedge clk);
        chk("reset_q", 130'(ifa.q), '0);
        chk("reset_q_valid", 130'(ifa.q_valid), '0);
        chk("reset_q_last", 130'(ifa.q_last), '0);
        chk("reset_state", 130'(ifa.state), '0);
        chk("reset_load_ready", 130'(ifa.load_ready), 130'(1));
        chk_en = 1'b1;

        // Single word 8'hB4, LSB first
        @(posedge clk); #1 ifa.load_valid = 1; ifa.load_data = 8'hB4; ifa.e = 1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1 ifa.load_valid = 0;
            @(negedge clk);
            s_q[k] = ifa.q; s_l[k] = ifa.q_last; s_r[k] = ifa.load_ready;
            if (k == 0) st1 = ifa.state;
            if (k == 1) st2 = ifa.state;
        end
        chk("single_q_seq", 130'(s_q[7:0]), 130'(8'hB4));
        chk("single_q_last", 130'(s_l[7:0]), 130'(8'h80));
        chk("single_load_ready", 130'(s_r[7:0]), 130'(8'h80));
        chk("single_state_c1", 130'(st1), 130'(8'hB4));
        chk("single_state_c2", 130'(st2), 130'(8'h5A));

        // Back-to-back 8'hFF then 8'h01 with load_valid held
        @(posedge clk); #1 ifa.load_valid = 1; ifa.load_data = 8'hFF; ifa.e = 1;
        @(posedge clk); #1 ifa.load_data = 8'h01;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            s_q[k] = ifa.q; s_v[k] = ifa.q_valid;
            if (ifa.load_ready && ifa.load_valid && k > 0) begin
                @(posedge clk); #1 ifa.load_valid = 0;
            end
        end
        chk("b2b_q_valid", 130'(s_v), 130'(17'h0FFFF));
        chk("b2b_q", 130'(s_q), 130'(17'h001FF));

        // Enable stall on 8'hA5
        @(posedge clk); #1 ifa.load_valid = 1; ifa.load_data = 8'hA5; ifa.e = 1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1 ifa.load_valid = 0; ifa.e = !(k >= 3 && k <= 6);
            @(negedge clk);
            s_q[k] = ifa.q; s_l[k] = ifa.q_last;
        end
        chk("stall_q_seq", 130'(s_q[11:0]), 130'(12'hA05));
        chk("stall_q_last", 130'(s_l[11:0]), 130'(12'h800));
        @(posedge clk); #1 ifa.e = 0;

        // Two lanes with an ignored load mid-word
        @(posedge clk); #1 ifb.load_valid = 1; ifb.load_data = 8'h3C; ifb.e = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1
            ifb.load_valid = (k == 2);
            ifb.load_data = (k == 0) ? 8'h3C : 8'hFF;
            @(negedge clk);
            s_q[k] = ifb.q[0]; s_l[k] = ifb.q[1]; s_v[k] = ifb.q_valid; s_r[k] = ifb.load_ready;
        end
        chk("lanes_q0", 130'(s_q[3:0]), 130'(4'hC));
        chk("lanes_q1", 130'(s_l[3:0]), 130'(4'h3));
        chk("lanes_ready_at_cnt2", 130'(s_r[2]), '0);
        chk("lanes_ignored_load", 130'(s_v[4:0]), 130'(5'h0F));
        @(posedge clk); #1 ifb.e = 0;

        // depth=130: reset mid-word with coincident load_valid, then a full word
        @(posedge clk); #1 ifc.load_valid = 1; ifc.load_data = '1; ifc.e = 1;
        @(posedge clk); #1 ifc.load_valid = 0;
        repeat (50) @(posedge clk);
        #1 rst_c = 1; ifc.load_valid = 1;
        @(posedge clk); #1 rst_c = 0; ifc.load_valid = 0;
        @(negedge clk);
        chk("rstmid_q_valid", 130'(ifc.q_valid), '0);
        chk("rstmid_state", ifc.state, '0);
        chk("rstmid_load_ready", 130'(ifc.load_ready), 130'(1));
        @(posedge clk); #1 ifc.load_valid = 1; ifc.load_data = r130();
        n_en = 0; n_last = 0; hit_at = 0; done = 0;
        for (int k = 0; k < 600 && !done; k++) begin
            @(posedge clk); #1 ifc.load_valid = 0; ifc.e = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ifc.q_valid && ifc.e) n_en++;
            if (ifc.q_last && ifc.e) begin n_last++; hit_at = n_en; done = 1; end
        end
        chk("full_word_done", 130'(done), 130'(1));
        chk("full_word_last_at", 130'(hit_at), 130'(130));
        @(posedge clk); #1 ifc.e = 0;

        // Randomized traffic on all three configurations
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1
            rst_a = ($urandom_range(0, 99) == 0);
            rst_b = ($urandom_range(0, 99) == 0);
            rst_c = ($urandom_range(0, 199) == 0);
            ifa.e = ($urandom_range(0, 3) != 0); ifa.load_valid = $urandom_range(0, 1);
            ifa.load_data = 8'($urandom);
            ifb.e = ($urandom_range(0, 3) != 0); ifb.load_valid = $urandom_range(0, 1);
            ifb.load_data = 8'($urandom);
            ifc.e = ($urandom_range(0, 3) != 0); ifc.load_valid = $urandom_range(0, 1);
            ifc.load_data = r130();
        end
        @(posedge clk); #1
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
